// File: rtl/order_pkg.sv
// Shared definitions for the grouped partial sorter: group/tag sizing helpers,
// the default latency template and the per-stage valid/desc sideband record.
package order_pkg;

  localparam int ORDER_GSIZE_DFLT = 4;
  // One register stage per odd-even transposition pass.
  localparam int ORDER_LAT_DFLT   = ORDER_GSIZE_DFLT;

  typedef struct packed {
    logic valid;
    logic desc;
  } order_sb_t;

  function automatic int order_num_groups(input int num, input int skip, input int gsize);
    return (num - skip + gsize - 1) / gsize;
  endfunction

  function automatic int order_idx_w(input int num);
    return (num > 1) ? $clog2(num) : 1;
  endfunction

endpackage

// File: rtl/order_oets_group.sv
// One group's registered odd-even transposition network: stage s compares
// pairs starting at index s%2. Optional source tags ride along (ORDER_SORT_INDEX_EN).
module order_oets_group
  import order_pkg::*;
#(
  parameter int DSIZE  = 64,
  parameter int KEYW   = 64,
  parameter int GLEN   = 4,
  parameter int STAGES = 4
`ifdef ORDER_SORT_INDEX_EN
  , parameter int IW   = 5
`endif
) (
  input  logic                    clock,
  input  logic                    rst_n,
  input  logic                    en_i,
  input  logic [STAGES-1:0]       desc_i,
  input  logic [GLEN*DSIZE-1:0]   data_i,
  output logic [GLEN*DSIZE-1:0]   data_o
`ifdef ORDER_SORT_INDEX_EN
  , input  logic [GLEN*IW-1:0]    idx_i
  , output logic [GLEN*IW-1:0]    idx_o
`endif
);

  logic [DSIZE-1:0] src   [STAGES][GLEN];
  logic [DSIZE-1:0] dat_d [STAGES][GLEN];
  logic [DSIZE-1:0] dat_q [STAGES][GLEN];
`ifdef ORDER_SORT_INDEX_EN
  logic [IW-1:0]    tsrc  [STAGES][GLEN];
  logic [IW-1:0]    tag_d [STAGES][GLEN];
  logic [IW-1:0]    tag_q [STAGES][GLEN];
`endif

  // Strict compare only, so equal keys never cross and the sort stays stable.
  always_comb begin
    logic swp;
    swp = 1'b0;
    for (int i = 0; i < GLEN; i++) begin
      src[0][i] = data_i[i*DSIZE +: DSIZE];
`ifdef ORDER_SORT_INDEX_EN
      tsrc[0][i] = idx_i[i*IW +: IW];
`endif
    end
    for (int s = 1; s < STAGES; s++) begin
      for (int i = 0; i < GLEN; i++) begin
        src[s][i] = dat_q[s-1][i];
`ifdef ORDER_SORT_INDEX_EN
        tsrc[s][i] = tag_q[s-1][i];
`endif
      end
    end
    for (int s = 0; s < STAGES; s++) begin
      for (int i = 0; i < GLEN; i++) begin
        dat_d[s][i] = src[s][i];
`ifdef ORDER_SORT_INDEX_EN
        tag_d[s][i] = tsrc[s][i];
`endif
      end
      for (int i = s % 2; i + 1 < GLEN; i += 2) begin
        swp = desc_i[s] ? (src[s][i][KEYW-1:0] < src[s][i+1][KEYW-1:0])
                        : (src[s][i][KEYW-1:0] > src[s][i+1][KEYW-1:0]);
        if (swp) begin
          dat_d[s][i]   = src[s][i+1];
          dat_d[s][i+1] = src[s][i];
`ifdef ORDER_SORT_INDEX_EN
          tag_d[s][i]   = tsrc[s][i+1];
          tag_d[s][i+1] = tsrc[s][i];
`endif
        end
      end
    end
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < STAGES; s++) begin
        for (int i = 0; i < GLEN; i++) begin
          dat_q[s][i] <= '0;
`ifdef ORDER_SORT_INDEX_EN
          tag_q[s][i] <= '0;
`endif
        end
      end
    end else if (en_i) begin
      for (int s = 0; s < STAGES; s++) begin
        for (int i = 0; i < GLEN; i++) begin
          dat_q[s][i] <= dat_d[s][i];
`ifdef ORDER_SORT_INDEX_EN
          tag_q[s][i] <= tag_d[s][i];
`endif
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < GLEN; i++) begin
      data_o[i*DSIZE +: DSIZE] = dat_q[STAGES-1][i];
`ifdef ORDER_SORT_INDEX_EN
      idx_o[i*IW +: IW] = tag_q[STAGES-1][i];
`endif
    end
  end

endmodule

// File: rtl/order_group_sort_pipe.sv
// Grouped partial sorter with valid/ready flow control: SKIP leading words are
// delay-matched, the rest sorted in GSIZE groups. Macro ORDER_SORT_INDEX_EN adds out_idx.
module order_group_sort_pipe
  import order_pkg::*;
#(
  parameter int DSIZE = 64,
  parameter int NUM   = 25,
  parameter int GSIZE = 4,
  parameter int SKIP  = 2,
  parameter int KEYW  = 64
) (
  input  logic                   clock,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_desc,
  input  logic [NUM*DSIZE-1:0]   in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NUM*DSIZE-1:0]   out_data
`ifdef ORDER_SORT_INDEX_EN
  , output logic [NUM*order_idx_w(NUM)-1:0] out_idx
`endif
);

  localparam int NG  = order_num_groups(NUM, SKIP, GSIZE);
  localparam int LAT = GSIZE;
`ifdef ORDER_SORT_INDEX_EN
  localparam int IW  = order_idx_w(NUM);
  logic [NUM*IW-1:0] idx_init;
  for (genvar i = 0; i < NUM; i++) begin : g_idx
    assign idx_init[i*IW +: IW] = IW'(i);
  end
`endif

  // Valid/ready contract: every stage shifts only when adv; in_ready is adv, so a
  // vector transfers on in_valid & adv and out_valid/out_data hold while stalled.
  logic            adv;
  order_sb_t       sb_q [LAT-1];
  logic            out_valid_q;
  logic [LAT-1:0]  desc_stg;

  assign adv       = !out_valid_q || out_ready;
  assign in_ready  = adv;
  assign out_valid = out_valid_q;

  // Each network stage sorts in the direction of the vector currently entering it.
  always_comb begin
    desc_stg[0] = in_desc;
    for (int s = 1; s < LAT; s++) desc_stg[s] = sb_q[s-1].desc;
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < LAT - 1; s++) sb_q[s] <= '0;
      out_valid_q <= 1'b0;
    end else if (adv) begin
      sb_q[0] <= '{valid: in_valid, desc: in_desc};
      for (int s = 1; s < LAT - 1; s++) sb_q[s] <= sb_q[s-1];
      out_valid_q <= sb_q[LAT-2].valid;
    end
  end

  for (genvar g = 0; g < NG; g++) begin : g_grp
    localparam int LO  = SKIP + g * GSIZE;
    localparam int LEN = (NUM - LO < GSIZE) ? (NUM - LO) : GSIZE;
    order_oets_group #(
      .DSIZE(DSIZE), .KEYW(KEYW), .GLEN(LEN), .STAGES(LAT)
`ifdef ORDER_SORT_INDEX_EN
      , .IW(IW)
`endif
    ) u_grp (
      .clock  (clock),
      .rst_n  (rst_n),
      .en_i   (adv),
      .desc_i (desc_stg),
      .data_i (in_data[LO*DSIZE +: LEN*DSIZE]),
      .data_o (out_data[LO*DSIZE +: LEN*DSIZE])
`ifdef ORDER_SORT_INDEX_EN
      , .idx_i (idx_init[LO*IW +: LEN*IW])
      , .idx_o (out_idx[LO*IW +: LEN*IW])
`endif
    );
  end

  if (SKIP > 0) begin : g_skip
    logic [SKIP*DSIZE-1:0] skip_q [LAT];
`ifdef ORDER_SORT_INDEX_EN
    logic [SKIP*IW-1:0]    sidx_q [LAT];
`endif
    always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
        for (int s = 0; s < LAT; s++) begin
          skip_q[s] <= '0;
`ifdef ORDER_SORT_INDEX_EN
          sidx_q[s] <= '0;
`endif
        end
      end else if (adv) begin
        skip_q[0] <= in_data[SKIP*DSIZE-1:0];
`ifdef ORDER_SORT_INDEX_EN
        sidx_q[0] <= idx_init[SKIP*IW-1:0];
`endif
        for (int s = 1; s < LAT; s++) begin
          skip_q[s] <= skip_q[s-1];
`ifdef ORDER_SORT_INDEX_EN
          sidx_q[s] <= sidx_q[s-1];
`endif
        end
      end
    end
    assign out_data[SKIP*DSIZE-1:0] = skip_q[LAT-1];
`ifdef ORDER_SORT_INDEX_EN
    assign out_idx[SKIP*IW-1:0] = sidx_q[LAT-1];
`endif
  end

endmodule

// File: tb/tb_order_group_sort_pipe.sv
// Scoreboard bench for order_group_sort_pipe: directed vectors, backpressure,
// mid-stream reset, random traffic, plus two small corner-configuration instances.
module tb_order_group_sort_pipe;

  localparam int N   = 25;
  localparam int DW  = 64;
  localparam int GS  = 4;
  localparam int SK  = 2;
  localparam int KW  = 32;
  localparam int LAT = GS;
  localparam int IW  = $clog2(N);

  logic            clock = 1'b0;
  logic            rst_n = 1'b1;
  logic            in_valid = 1'b0;
  logic            in_desc = 1'b0;
  logic [N*DW-1:0] in_data = '0;
  logic            in_ready;
  logic            out_valid;
  logic            out_ready = 1'b1;
  logic [N*DW-1:0] out_data;
`ifdef ORDER_SORT_INDEX_EN
  logic [N*IW-1:0] out_idx;
  logic [14:0]     t_idx;
  logic [5:0]      d_idx;
`endif

  logic            c_valid = 1'b0;
  logic [39:0]     c_data5 = '0;
  logic [23:0]     c_data3 = '0;
  logic            t_in_ready, t_out_valid, d_in_ready, d_out_valid;
  logic [39:0]     t_out_data;
  logic [23:0]     d_out_data;

  logic [N*DW-1:0] exp_q[$];
  logic [N*IW-1:0] exp_idx_q[$];
  int              n_checks = 0;
  int              n_errors = 0;
  int              cyc = 0;
  int              bp_base = 0;
  int              rdy_mode = 0;

  order_group_sort_pipe #(.DSIZE(DW), .NUM(N), .GSIZE(GS), .SKIP(SK), .KEYW(KW)) dut (
    .clock(clock), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_desc(in_desc), .in_data(in_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data)
`ifdef ORDER_SORT_INDEX_EN
    , .out_idx(out_idx)
`endif
  );

  order_group_sort_pipe #(.DSIZE(8), .NUM(5), .GSIZE(4), .SKIP(0), .KEYW(8)) u_tail (
    .clock(clock), .rst_n(rst_n), .in_valid(c_valid), .in_ready(t_in_ready),
    .in_desc(1'b0), .in_data(c_data5), .out_valid(t_out_valid),
    .out_ready(1'b1), .out_data(t_out_data)
`ifdef ORDER_SORT_INDEX_EN
    , .out_idx(t_idx)
`endif
  );

  order_group_sort_pipe #(.DSIZE(8), .NUM(3), .GSIZE(3), .SKIP(2), .KEYW(8)) u_dly (
    .clock(clock), .rst_n(rst_n), .in_valid(c_valid), .in_ready(d_in_ready),
    .in_desc(1'b0), .in_data(c_data3), .out_valid(d_out_valid),
    .out_ready(1'b1), .out_data(d_out_data)
`ifdef ORDER_SORT_INDEX_EN
    , .out_idx(d_idx)
`endif
  );

  // Clock/reset block and out_ready pattern generator
  always #5 clock = ~clock;

  always @(posedge clock) begin
    cyc++;
    #1;
    case (rdy_mode)
      1:       out_ready = ($urandom_range(0, 3) != 0);
      2:       out_ready = !((cyc - bp_base) >= 5 && (cyc - bp_base) <= 8);
      default: out_ready = 1'b1;
    endcase
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish, errors=%0d", n_errors);
    $fatal(1, "watchdog");
  end

  task automatic check_bit(input string name, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_vec(input string name, input logic [N*DW-1:0] got, input logic [N*DW-1:0] exp);
    int j;
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      j = 0;
      while (j < N - 1 && got[j*DW +: DW] === exp[j*DW +: DW]) j++;
      $display("FAIL %s: word %0d got %h expected %h at %0t", name, j, got[j*DW +: DW], exp[j*DW +: DW], $time);
    end
  endtask

  task automatic check_idx(input string name, input logic [N*IW-1:0] got, input logic [N*IW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: per group, repeatedly take the earliest word with the extreme key.
  function automatic logic [KW-1:0] key_of(input logic [DW-1:0] w);
    return w[KW-1:0];
  endfunction

  function automatic void model(input logic [N*DW-1:0] din, input logic desc,
                                output logic [N*DW-1:0] dout, output logic [N*IW-1:0] iout);
    int rem[$];
    int pick, k;
    logic [DW-1:0] w [N];
    for (int i = 0; i < N; i++) begin
      w[i] = din[i*DW +: DW];
      iout[i*IW +: IW] = IW'(i);
    end
    dout = din;
    for (int lo = SK; lo < N; lo += GS) begin
      rem.delete();
      for (int p = lo; p < lo + GS && p < N; p++) rem.push_back(p);
      k = lo;
      while (rem.size() > 0) begin
        pick = 0;
        for (int j = 1; j < rem.size(); j++) begin
          if (desc ? (key_of(w[rem[j]]) > key_of(w[rem[pick]]))
                   : (key_of(w[rem[j]]) < key_of(w[rem[pick]]))) pick = j;
        end
        dout[k*DW +: DW] = w[rem[pick]];
        iout[k*IW +: IW] = IW'(rem[pick]);
        rem.delete(pick);
        k++;
      end
    end
  endfunction

  // Driver tasks (called at posedge+1, return at posedge+1)
  task automatic send_vec(input logic [N*DW-1:0] d, input logic desc,
                          input logic [N*DW-1:0] e, input logic [N*IW-1:0] ei);
    int  waitc = 0;
    bit  done = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_desc  = desc;
    while (!done) begin
      @(negedge clock);
      if (in_ready) begin
        exp_q.push_back(e);
        exp_idx_q.push_back(ei);
        done = 1;
      end else if (++waitc > 100) begin
        n_checks++;
        n_errors++;
        $display("FAIL accept_timeout: got in_ready=0 for %0d cycles expected acceptance", waitc);
        done = 1;
      end
      @(posedge clock);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic send_model(input logic [N*DW-1:0] d, input logic desc);
    logic [N*DW-1:0] e;
    logic [N*IW-1:0] ei;
    model(d, desc, e, ei);
    send_vec(d, desc, e, ei);
  endtask

  function automatic logic [N*DW-1:0] rand_vec();
    logic [N*DW-1:0] d;
    for (int i = 0; i < N; i++) d[i*DW +: DW] = {32'($urandom()), 32'($urandom_range(0, 7))};
    return d;
  endfunction

  task automatic measure_lat(input string name);
    int cnt = 1;
    bit seen = 0;
    while (!seen && cnt < 20) begin
      @(negedge clock);
      if (out_valid) seen = 1;
      else begin
        @(posedge clock);
        cnt++;
      end
    end
    check_int(name, seen ? cnt : -1, LAT);
    @(posedge clock);
    #1;
  endtask

  task automatic drain(input string name);
    int c = 0;
    while (exp_q.size() != 0 && c < 400) begin
      @(posedge clock);
      c++;
    end
    check_int(name, exp_q.size(), 0);
    @(posedge clock);
    #1;
  endtask

  // Monitor / scoreboard
  logic            stall_prev = 1'b0;
  logic [N*DW-1:0] prev_data = '0;

  always @(negedge clock) begin
    logic [N*DW-1:0] e;
    logic [N*IW-1:0] ei;
    if (!rst_n) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        check_bit("hold_valid", out_valid, 1'b1);
        check_vec("hold_data", out_data, prev_data);
      end
      check_bit("in_ready", in_ready, !(out_valid && !out_ready));
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_out: got out_valid=1 expected no output at %0t", $time);
        end else begin
          e  = exp_q.pop_front();
          ei = exp_idx_q.pop_front();
          check_vec("out_data", out_data, e);
`ifdef ORDER_SORT_INDEX_EN
          check_idx("out_idx", out_idx, ei);
`endif
        end
      end
      stall_prev = out_valid && !out_ready;
      prev_data  = out_data;
    end
  end

  int t1 [N] = '{24, 23, 19, 20, 21, 22, 15, 16, 17, 18, 11, 12, 13, 14,
                 7, 8, 9, 10, 3, 4, 5, 6, 0, 1, 2};

  initial begin
    logic [N*DW-1:0] d, e;
    logic [N*IW-1:0] ei;
    int t_lat, d_lat, cnt;

    #1 rst_n = 1'b0;
    #2;
    check_bit("rst_out_valid", out_valid, 1'b0);
    check_vec("rst_out_data", out_data, '0);
`ifdef ORDER_SORT_INDEX_EN
    check_idx("rst_out_idx", out_idx, '0);
`endif
    repeat (2) @(posedge clock);
    #1 rst_n = 1'b1;
    @(negedge clock);
    check_bit("rst_in_ready", in_ready, 1'b1);
    @(posedge clock);
    #1;

    // Descending input, ascending sort
    for (int i = 0; i < N; i++) begin
      d[i*DW +: DW] = DW'(24 - i);
      e[i*DW +: DW] = DW'(t1[i]);
    end
    model(d, 1'b0, prev_data, ei);
    send_vec(d, 1'b0, e, ei);
    measure_lat("lat_asc");
    drain("drain_asc");

    // Already descending, descending sort: unchanged
    for (int i = 0; i < N; i++) ei[i*IW +: IW] = IW'(i);
    send_vec(d, 1'b1, d, ei);
    drain("drain_desc");

    // Stability: keys {5,5,1,5} in group 0, zero keys elsewhere
    for (int i = 0; i < N; i++) begin
      d[i*DW +: DW]  = {32'(i + 100), 32'd0};
      ei[i*IW +: IW] = IW'(i);
    end
    d[2*DW +: DW] = {32'hA, 32'd5};
    d[3*DW +: DW] = {32'hB, 32'd5};
    d[4*DW +: DW] = {32'hC, 32'd1};
    d[5*DW +: DW] = {32'hD, 32'd5};
    e = d;
    e[2*DW +: DW] = d[4*DW +: DW];
    e[3*DW +: DW] = d[2*DW +: DW];
    e[4*DW +: DW] = d[3*DW +: DW];
    e[5*DW +: DW] = d[5*DW +: DW];
    ei[2*IW +: IW] = IW'(4);
    ei[3*IW +: IW] = IW'(2);
    ei[4*IW +: IW] = IW'(3);
    ei[5*IW +: IW] = IW'(5);
    send_vec(d, 1'b0, e, ei);
    drain("drain_stable");

    // Backpressure window on 6 back-to-back vectors
    rdy_mode = 2;
    bp_base  = cyc;
    for (int v = 0; v < 6; v++) send_model(rand_vec(), 1'($urandom_range(0, 1)));
    drain("drain_bp");
    rdy_mode = 0;

    // Reset with one vector at the output and three in flight
    for (int v = 0; v < 4; v++) send_model(rand_vec(), 1'b0);
    check_bit("pre_rst_valid", out_valid, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    check_bit("mid_rst_valid", out_valid, 1'b0);
    check_vec("mid_rst_data", out_data, '0);
    exp_q.delete();
    exp_idx_q.delete();
    repeat (2) @(posedge clock);
    #1 rst_n = 1'b1;
    @(posedge clock);
    #1;
    send_model(rand_vec(), 1'b1);
    measure_lat("lat_after_rst");
    drain("drain_rst");
    repeat (8) @(posedge clock);
    #1;

    // Random traffic with random backpressure
    rdy_mode = 1;
    for (int v = 0; v < 150; v++) begin
      send_model(rand_vec(), 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) begin
        @(posedge clock);
        #1;
      end
    end
    rdy_mode = 0;
    drain("drain_rand");

    // Corner configurations: 1-word tail group and pure delay line
    c_data5 = {8'd3, 8'd6, 8'd7, 8'd8, 8'd9};
    c_data3 = 24'($urandom());
    c_valid = 1'b1;
    @(negedge clock);
    check_bit("tail_in_ready", t_in_ready, 1'b1);
    check_bit("dly_in_ready", d_in_ready, 1'b1);
    @(posedge clock);
    #1 c_valid = 1'b0;
    cnt = 1; t_lat = 0; d_lat = 0;
    while (cnt < 12) begin
      @(negedge clock);
      if (t_out_valid && t_lat == 0) begin
        t_lat = cnt;
        check_vec("tail_data", (N*DW)'(t_out_data), (N*DW)'({8'd3, 8'd9, 8'd8, 8'd7, 8'd6}));
      end
      if (d_out_valid && d_lat == 0) begin
        d_lat = cnt;
        check_vec("dly_data", (N*DW)'(d_out_data), (N*DW)'(c_data3));
      end
      @(posedge clock);
      cnt++;
    end
    check_int("tail_lat", t_lat, 4);
    check_int("dly_lat", d_lat, 3);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
